// File: rtl/fast_square_rx_recorder.sv
// Record-window framer: header word, then boxcar-averaged I/Q words, into a FWFT output FIFO.
// Define RECORDER_TRAILER_EN to append a trailer word (overflow flag + data-word count) per window.
module fast_square_rx_recorder #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_LOG2 = 2,
  parameter int DEPTH    = 512
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx_record,
  input  logic                       rx_next,
  input  logic                       rx_reset,
  input  logic                       sample_strobe,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic [7:0]                 step_index
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ACC_W = SAMPLE_W + ACC_LOG2;
  localparam int GROUP = 1 << ACC_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CAP
`ifdef RECORDER_TRAILER_EN
    , TRL
`endif
  } state_t;

  state_t state, state_nxt;

  // Controller strobes: edge detect and sweep/step bookkeeping
  logic rx_record_q, rx_reset_q;
  logic record_rise, reset_rise, next_ok;
  logic [7:0] sweep_id;

  assign reset_rise  = rx_reset && !rx_reset_q;
  assign record_rise = rx_record && !rx_record_q && !rx_reset;
  assign next_ok     = rx_next && !rx_reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_record_q <= 1'b0;
      rx_reset_q  <= 1'b0;
    end else begin
      rx_record_q <= rx_record;
      rx_reset_q  <= rx_reset;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sweep_id   <= '0;
      step_index <= '0;
    end else if (reset_rise) begin
      sweep_id   <= sweep_id + 8'd1;
      step_index <= '0;
    end else if (next_ok) begin
      step_index <= step_index + 8'd1;
    end
  end

  // Boxcar accumulators; a finished group is registered and pushed the following cycle
  logic signed [ACC_W-1:0] sum_i, sum_q, next_sum_i, next_sum_q;
  logic [ACC_LOG2:0]       acc_cnt;
  logic                    acc_en, acc_clr, group_done;
  logic [SAMPLE_W-1:0]     mean_i, mean_q;
  logic                    pend_valid;
  logic [31:0]             pend_word;

  assign acc_en  = sample_strobe && !reset_rise &&
                   ((state == HDR) || ((state == CAP) && rx_record));
  assign acc_clr = reset_rise || ((state == CAP) && !rx_record);

  assign next_sum_i = sum_i + ACC_W'(sample_i);
  assign next_sum_q = sum_q + ACC_W'(sample_q);
  assign group_done = acc_en && (acc_cnt == (ACC_LOG2 + 1)'(GROUP - 1));

  // Arithmetic shift floors toward -inf; the mean always fits SAMPLE_W
  assign mean_i = SAMPLE_W'(next_sum_i >>> ACC_LOG2);
  assign mean_q = SAMPLE_W'(next_sum_q >>> ACC_LOG2);

  always_ff @(posedge clock) begin
    if (reset || acc_clr) begin
      sum_i   <= '0;
      sum_q   <= '0;
      acc_cnt <= '0;
    end else if (acc_en) begin
      if (group_done) begin
        sum_i   <= '0;
        sum_q   <= '0;
        acc_cnt <= '0;
      end else begin
        sum_i   <= next_sum_i;
        sum_q   <= next_sum_q;
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
    end else begin
      pend_valid <= group_done;
      if (group_done) pend_word <= {mean_i, mean_q};
    end
  end

`ifdef RECORDER_TRAILER_EN
  logic [15:0] record_words;

  always_ff @(posedge clock) begin
    if (reset || (state == HDR)) record_words <= '0;
    else if (pend_valid && (record_words != 16'hFFFF)) record_words <= record_words + 16'd1;
  end
`endif

  // Framing FSM: selects at most one word to push per cycle
  logic        push_req;
  logic [31:0] push_word;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_word = '0;
    if (pend_valid) begin
      push_req  = 1'b1;
      push_word = pend_word;
    end
    unique case (state)
      IDLE: if (record_rise) state_nxt = HDR;
      HDR: begin
        push_req  = 1'b1;
        push_word = {8'hA5, sweep_id, step_index, 8'h00};
        state_nxt = CAP;
      end
      CAP: begin
        if (!rx_record) begin
`ifdef RECORDER_TRAILER_EN
          state_nxt = TRL;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef RECORDER_TRAILER_EN
      TRL: begin
        push_req  = 1'b1;
        push_word = {8'h5A, overflow, 7'b0, record_words};
        state_nxt = record_rise ? HDR : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (reset_rise) state_nxt = IDLE;
  end

  // First-word-fall-through FIFO
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, push_ok;

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fill_level = count;
  assign pop        = out_valid && out_ready;
  assign push_ok    = push_req && ((count != (AW + 1)'(DEPTH)) || pop);

  // NOTE: the storage array carries no reset; pointers and count alone define which words are valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag, cleared by a sweep restart
  always_ff @(posedge clock) begin
    if (reset || reset_rise)      overflow <= 1'b0;
    else if (push_req && !push_ok) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_fast_square_rx_recorder.sv
// Self-checking bench for fast_square_rx_recorder: word-level scoreboard fed by a window model,
// directed framing/averaging/overflow/restart cases plus randomized windows.
module tb_fast_square_rx_recorder;

  localparam int SAMPLE_W = 16;
  localparam int ACC_LOG2 = 2;
  localparam int DEPTH    = 8;
  localparam int GROUP    = 1 << ACC_LOG2;
`ifdef RECORDER_TRAILER_EN
  localparam int TRL_WORDS = 1;
`else
  localparam int TRL_WORDS = 0;
`endif

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       rx_record, rx_next, rx_reset, sample_strobe, out_ready;
  logic signed [SAMPLE_W-1:0] sample_i, sample_q;
  logic [31:0]                out_data;
  logic                       out_valid, overflow;
  logic [$clog2(DEPTH):0]     fill_level;
  logic [7:0]                 step_index;

  fast_square_rx_recorder #(.SAMPLE_W(SAMPLE_W), .ACC_LOG2(ACC_LOG2), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rx_record(rx_record), .rx_next(rx_next),
    .rx_reset(rx_reset), .sample_strobe(sample_strobe), .sample_i(sample_i),
    .sample_q(sample_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fill_level(fill_level), .overflow(overflow),
    .step_index(step_index)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [7:0]  exp_sweep = '0;
  logic [7:0]  exp_step = '0;
  logic        exp_ovf = 1'b0;
  logic        prev_rx_reset = 1'b0;
  int          ready_mode = 2;
  bit          in_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: ready chosen per mode, then spec-level bookkeeping of sweep/step indices
  task automatic step();
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b1;
    endcase
    @(posedge clock);
    #1;
    if (rx_reset && !prev_rx_reset) begin
      exp_sweep = exp_sweep + 8'd1;
      exp_step  = '0;
      exp_ovf   = 1'b0;
    end else if (rx_next && !rx_reset) begin
      exp_step = exp_step + 8'd1;
    end
    prev_rx_reset = rx_reset;
  endtask

  // Model FIFO: capacity is enforced only while nothing drains
  task automatic model_push(input logic [31:0] w);
    if (ready_mode == 0 && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  function automatic int floor_div(input int s);
    int q;
    q = s / GROUP;
    if ((s % GROUP != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic gen(input int mode, input int k, output logic strb,
                     output logic signed [15:0] vi, output logic signed [15:0] vq);
    int t2_i[4];
    int t2_q[4];
    t2_i = '{-1, -2, -1, -2};
    t2_q = '{3, 3, 3, 2};
    strb = 1'b0;
    vi   = '0;
    vq   = '0;
    case (mode)
      1: begin strb = 1'b1; vi = 16'sd4; vq = -16'sd4; end
      2: if (k >= 1 && k <= 4) begin
           strb = 1'b1;
           vi   = 16'(t2_i[k-1]);
           vq   = 16'(t2_q[k-1]);
         end
      default: begin
        strb = ($urandom_range(1) == 1);
        vi   = 16'($urandom);
        vq   = 16'($urandom);
      end
    endcase
  endtask

  // A window: rx_record high for len cycles (k=0 is the rise), fall cycle at k=len.
  // Samples count from the cycle after the rise through the last high cycle.
  task automatic run_window(input int len, input int mode, input int next_at,
                            input int rst_at, output int n_words);
    int   acc_i, acc_q, cnt;
    logic strb;
    logic signed [15:0] vi, vq;
    bit   aborted;
    acc_i = 0; acc_q = 0; cnt = 0; n_words = 0; aborted = 0;
    for (int k = 0; k <= len; k++) begin
      if (k == rst_at) begin
        aborted = 1;
        break;
      end
      gen(mode, k, strb, vi, vq);
      rx_record     = (k < len);
      sample_strobe = strb;
      sample_i      = vi;
      sample_q      = vq;
      rx_next       = (k == next_at) || (mode == 0 && $urandom_range(15) == 0);
      if (k == 1) model_push({8'hA5, exp_sweep, exp_step, 8'h00});
      if (k >= 1 && k < len && strb) begin
        acc_i += int'(vi);
        acc_q += int'(vq);
        cnt++;
        if (cnt == GROUP) begin
          model_push({16'(floor_div(acc_i)), 16'(floor_div(acc_q))});
          n_words++;
          acc_i = 0; acc_q = 0; cnt = 0;
        end
      end
      step();
    end
    rx_next = 1'b0;
    sample_strobe = 1'b0;
    if (aborted) begin
      rx_reset = 1'b1;
      sample_strobe = 1'b1;
      for (int c = 0; c < 10; c++) begin
        if (c == 5) rx_record = 1'b0;
        step();
      end
      rx_reset = 1'b0;
      rx_record = 1'b0;
      sample_strobe = 1'b0;
      step();
    end else begin
`ifdef RECORDER_TRAILER_EN
      model_push({8'h5A, exp_ovf, 7'b0, 16'(n_words)});
`endif
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ready_mode = 2;
    rx_record = 1'b0; rx_next = 1'b0; sample_strobe = 1'b0;
    while ((exp_q.size() != 0 || fill_level != 0) && n < 300) begin
      step();
      n++;
    end
    repeat (2) step();
    check({name, "_fill_zero"}, 32'(fill_level), 32'h0);
    check({name, "_model_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  // Compare process: every handshake against the scoreboard, plus per-cycle output rules
  always @(negedge clock) begin
    if (!in_reset) begin
      check("valid_vs_fill", 32'(out_valid), 32'(fill_level != 0));
      if (!out_valid) check("idle_data_zero", out_data, 32'h0);
      check("step_index", 32'(step_index), 32'(exp_step));
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h, expected no word", out_data);
        end else begin
          check("fifo_word", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base, n;
    reset = 1'b1;
    rx_record = 1'b0; rx_next = 1'b0; rx_reset = 1'b0;
    sample_strobe = 1'b0; sample_i = '0; sample_q = '0; out_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_fill", 32'(fill_level), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_step", 32'(step_index), 32'h0);
    reset = 1'b0;
    in_reset = 1'b0;
    step();

    // Constant I=4, Q=-4 for 20 record cycles: 19 samples -> 4 words, partial dropped
    base = got_q.size();
    run_window(20, 1, -1, -1, n);
    check("t1_model_words", 32'(n), 32'd4);
    drain("t1");
    check("t1_count", 32'(got_q.size() - base), 32'(5 + TRL_WORDS));
    check("t1_header", got_q[base], 32'hA500_0000);
    for (int i = 1; i <= 4; i++) check("t1_data", got_q[base+i], 32'h0004_FFFC);
`ifdef RECORDER_TRAILER_EN
    check("t1_trailer", got_q[base+5], 32'h5A00_0004);
`endif

    // Negative floor rounding
    base = got_q.size();
    run_window(6, 2, -1, -1, n);
    drain("t2");
    check("t2_count", 32'(got_q.size() - base), 32'(2 + TRL_WORDS));
    check("t2_header", got_q[base], 32'hA500_0000);
    check("t2_data", got_q[base+1], 32'hFFFE_0002);

    // rx_next on the last record cycle, then two idle pulses
    base = got_q.size();
    run_window(5, 1, 4, -1, n);
    run_window(5, 1, -1, -1, n);
    for (int i = 0; i < 2; i++) begin
      rx_next = 1'b1; step();
      rx_next = 1'b0; step();
    end
    check("t3_step", 32'(step_index), 32'd3);
    run_window(5, 1, -1, -1, n);
    drain("t3");
    check("t3_hdr0", got_q[base], 32'hA500_0000);
    check("t3_hdr1", got_q[base + (2 + TRL_WORDS)], 32'hA500_0100);
    check("t3_hdr2", got_q[base + 2*(2 + TRL_WORDS)], 32'hA500_0300);

    // Host stalled: 10 pushes into an 8-deep FIFO
    ready_mode = 0;
    run_window(37, 1, -1, -1, n);
    repeat (3) step();
    check("t5_fill", 32'(fill_level), 32'd8);
    check("t5_overflow", 32'(overflow), 32'h1);
    check("t5_head", out_data, 32'hA500_0300);
    base = got_q.size();
    drain("t5");
    check("t5_drained", 32'(got_q.size() - base), 32'd8);
    check("t5_first", got_q[base], 32'hA500_0300);
    check("t5_last", got_q[base+7], 32'h0004_FFFC);

    // Sweep restart mid-capture
    base = got_q.size();
    run_window(20, 1, -1, 7, n);
    check("t4_step", 32'(step_index), 32'h0);
    check("t4_overflow", 32'(overflow), 32'h0);
    run_window(5, 1, -1, -1, n);
    drain("t4");
    check("t4_count", 32'(got_q.size() - base), 32'(4 + TRL_WORDS));
    check("t4_old_hdr", got_q[base], 32'hA500_0300);
    check("t4_new_hdr", got_q[base+2], 32'hA501_0000);

`ifdef RECORDER_TRAILER_EN
    // Trailer, and a new rise landing in the trailer cycle
    base = got_q.size();
    run_window(13, 1, -1, -1, n);
    run_window(5, 1, -1, -1, n);
    drain("t6");
    check("t6_header", got_q[base], 32'hA501_0000);
    check("t6_trailer", got_q[base+4], 32'h5A00_0003);
    check("t6_next_hdr", got_q[base+5], 32'hA501_0000);
`endif

    // Randomized windows, gaps, step pulses and sweep restarts
    ready_mode = 1;
    for (int w = 0; w < 40; w++) begin
      run_window($urandom_range(30, 2), 0, -1, -1, n);
      rx_record = 1'b0; sample_strobe = 1'b0;
      repeat ($urandom_range(3)) begin
        rx_next = ($urandom_range(3) == 0);
        step();
        rx_next = 1'b0;
      end
      if ($urandom_range(7) == 0) begin
        repeat (2) step();
        rx_reset = 1'b1;
        repeat ($urandom_range(4, 1)) step();
        rx_reset = 1'b0;
        step();
      end
    end
    drain("rand");
    check("rand_overflow", 32'(overflow), 32'(exp_ovf));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
